// File: rtl/spi_frame_responder_if.sv
`timescale 1ns/1ps
// SPI pin and frame-RAM port bundle for spi_frame_responder.
// slave is the responder's view; master is the far-end SPI host plus the RAM.
interface spi_frame_responder_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              spi_cs;
  logic              spi_sck;
  logic              spi_si;
  logic              spi_so;
  logic              spi_so_oe;
  logic [ADDR_W-1:0] mem_raddr;
  logic [7:0]        mem_rdata;
  logic [ADDR_W-1:0] mem_waddr;
  logic [7:0]        mem_wdata;
  logic              mem_we;
  logic              busy;
  logic              cmd_err;

  modport slave (
    input  spi_cs, spi_sck, spi_si, mem_rdata,
    output spi_so, spi_so_oe, mem_raddr, mem_waddr, mem_wdata, mem_we, busy, cmd_err
  );

  modport master (
    output spi_cs, spi_sck, spi_si, mem_rdata,
    input  spi_so, spi_so_oe, mem_raddr, mem_waddr, mem_wdata, mem_we, busy, cmd_err
  );
endinterface

// File: rtl/spi_frame_responder.sv
`timescale 1ns/1ps
// SPI mode-0 slave that serves READ/WRITE frames from an on-chip frame RAM.
// All SPI pins are oversampled and edge-detected in the clk_50 domain.
module spi_frame_responder #(
  parameter int unsigned ADDR_W      = 10,
  parameter logic [7:0]  CMD_READ    = 8'h03,
  parameter logic [7:0]  CMD_WRITE   = 8'h02,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                   clk_50,
  input  logic                   reset,
  spi_frame_responder_if.slave   bus
);
  localparam int unsigned RX_W = (ADDR_W > 8) ? ADDR_W : 8;

  typedef enum logic [2:0] {
    WAIT_CS, IDLE, CMD, ADDR, RD_LOAD, RD_DATA, WR_DATA, IGNORE
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] cs_sync, sck_sync, si_sync;
  logic                   sck_prev;
  logic                   is_rd;
  logic                   skip_fall;
  logic [RX_W-2:0]        rx;
  logic [4:0]             bit_cnt;
  logic [ADDR_W-1:0]      addr;
  logic [6:0]             tx;
  logic [7:0]             pf;
  logic [1:0]             rd_pipe;

  logic              cs_s, sck_s, si_s, sck_rise, sck_fall;
  logic [RX_W-1:0]   rx_next;
  logic [ADDR_W-1:0] rx_addr, addr_inc;

  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign si_s     = si_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev & ~cs_s;
  assign sck_fall = ~sck_s & sck_prev & ~cs_s;
  assign rx_next  = {rx, si_s};
  assign rx_addr  = rx_next[ADDR_W-1:0];
  assign addr_inc = addr + ADDR_W'(1);

  // Sync chains reset to cs low so a mid-frame reset cannot look like an idle bus.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      state         <= WAIT_CS;
      cs_sync       <= '0;
      sck_sync      <= '0;
      si_sync       <= '0;
      sck_prev      <= 1'b0;
      is_rd         <= 1'b0;
      skip_fall     <= 1'b0;
      rx            <= '0;
      bit_cnt       <= '0;
      addr          <= '0;
      tx            <= '0;
      pf            <= '0;
      rd_pipe       <= '0;
      bus.spi_so    <= 1'b0;
      bus.spi_so_oe <= 1'b0;
      bus.mem_raddr <= '0;
      bus.mem_waddr <= '0;
      bus.mem_wdata <= '0;
      bus.mem_we    <= 1'b0;
      bus.busy      <= 1'b0;
      bus.cmd_err   <= 1'b0;
    end else begin
      cs_sync     <= {cs_sync[SYNC_STAGES-2:0], bus.spi_cs};
      sck_sync    <= {sck_sync[SYNC_STAGES-2:0], bus.spi_sck};
      si_sync     <= {si_sync[SYNC_STAGES-2:0], bus.spi_si};
      sck_prev    <= sck_s;
      rd_pipe     <= {rd_pipe[0], 1'b0};
      bus.mem_we  <= 1'b0;
      bus.cmd_err <= 1'b0;
      if (sck_rise) rx <= rx_next[RX_W-2:0];

      if (cs_s && state != WAIT_CS && state != IDLE) begin
        state         <= IDLE;
        bus.spi_so    <= 1'b0;
        bus.spi_so_oe <= 1'b0;
        bus.busy      <= 1'b0;
        rd_pipe       <= '0;
      end else begin
        case (state)
          WAIT_CS: if (cs_s) state <= IDLE;
          IDLE: if (!cs_s) begin
            state    <= CMD;
            bus.busy <= 1'b1;
            bit_cnt  <= '0;
          end
          CMD: if (sck_rise) begin
            if (bit_cnt == 5'd7) begin
              bit_cnt <= '0;
              if (rx_next[7:0] == CMD_READ) begin
                is_rd <= 1'b1;
                state <= ADDR;
              end else if (rx_next[7:0] == CMD_WRITE) begin
                is_rd <= 1'b0;
                state <= ADDR;
              end else begin
                bus.cmd_err <= 1'b1;
                state       <= IGNORE;
              end
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          // Read address goes straight to the RAM port to keep the first-bit latency short.
          ADDR: if (sck_rise) begin
            if (bit_cnt == 5'd23) begin
              bit_cnt <= '0;
              addr    <= rx_addr;
              if (is_rd) begin
                bus.mem_raddr <= rx_addr;
                rd_pipe[0]    <= 1'b1;
                state         <= RD_LOAD;
              end else begin
                state <= WR_DATA;
              end
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          RD_LOAD: if (rd_pipe[1]) begin
            tx            <= bus.mem_rdata[6:0];
            bus.spi_so    <= bus.mem_rdata[7];
            bus.spi_so_oe <= 1'b1;
            skip_fall     <= 1'b1;
            bit_cnt       <= '0;
            bus.mem_raddr <= addr_inc;
            addr          <= addr_inc;
            rd_pipe[0]    <= 1'b1;
            state         <= RD_DATA;
          end
          // The falling edge right after the last address bit must keep the MSB on the line.
          RD_DATA: begin
            if (rd_pipe[1]) pf <= bus.mem_rdata;
            if (sck_fall) begin
              if (skip_fall) begin
                skip_fall <= 1'b0;
              end else if (bit_cnt == 5'd7) begin
                tx            <= pf[6:0];
                bus.spi_so    <= pf[7];
                bit_cnt       <= '0;
                bus.mem_raddr <= addr_inc;
                addr          <= addr_inc;
                rd_pipe[0]    <= 1'b1;
              end else begin
                tx         <= {tx[5:0], 1'b0};
                bus.spi_so <= tx[6];
                bit_cnt    <= bit_cnt + 5'd1;
              end
            end
          end
          WR_DATA: if (sck_rise) begin
            if (bit_cnt == 5'd7) begin
              bit_cnt       <= '0;
              bus.mem_waddr <= addr;
              bus.mem_wdata <= rx_next[7:0];
              bus.mem_we    <= 1'b1;
              addr          <= addr_inc;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          IGNORE: bus.spi_so_oe <= 1'b0;
          default: state <= WAIT_CS;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_spi_frame_responder.sv
`timescale 1ns/1ps
// Self-checking bench for spi_frame_responder: SPI master, frame RAM model and
// write/read scoreboards driven from a vector table plus corner-case sequences.
module tb_spi_frame_responder;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int          HALF   = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [7:0]        d;
  } wr_t;

  typedef struct {
    logic [7:0]  op;
    logic [23:0] addr;
    int          nbytes;
    logic [31:0] data;
    int          exp_err;
    int          exp_we;
  } vec_t;

  logic clk_50 = 1'b0;
  logic reset;
  logic ram_init;

  spi_frame_responder_if #(.ADDR_W(ADDR_W)) bus ();
  spi_frame_responder #(.ADDR_W(ADDR_W)) dut (.clk_50(clk_50), .reset(reset), .bus(bus));

  always #5 clk_50 = ~clk_50;

  int vec_cnt = 0;
  int err_cnt = 0;
  int we_seen = 0;
  int err_seen = 0;
  int oe_bad = 0;
  logic oe_allow = 1'b0;

  logic [7:0] ram    [DEPTH];
  logic [7:0] shadow [DEPTH];
  wr_t        wr_q[$];
  logic [7:0] rd_q[$];
  wr_t        mon_w;
  vec_t       vecs[7];

  function automatic logic [7:0] init_byte(input int i);
    case (i)
      5:       return 8'hA5;
      6:       return 8'h3C;
      default: return 8'((i * 37) + 11);
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Synchronous frame RAM: read data one cycle after the address.
  always @(posedge clk_50) begin
    bus.mem_rdata <= ram[bus.mem_raddr];
    if (ram_init) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= init_byte(i);
    end else if (bus.mem_we) begin
      ram[bus.mem_waddr] <= bus.mem_wdata;
    end
  end

  // Write scoreboard and pulse counters.
  always @(negedge clk_50) begin
    if (!reset) begin
      if (bus.cmd_err) err_seen++;
      if (bus.spi_so_oe && !oe_allow) oe_bad++;
      if (bus.mem_we) begin
        we_seen++;
        if (wr_q.size() == 0) begin
          check("we_unexpected", 32'(bus.mem_we), 32'd0);
        end else begin
          mon_w = wr_q.pop_front();
          check("wr_addr", 32'(bus.mem_waddr), 32'(mon_w.a));
          check("wr_data", 32'(bus.mem_wdata), 32'(mon_w.d));
        end
      end
    end
  end

  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i > 7 - n; i--) begin
      bus.spi_si = tx[i];
      repeat (HALF) @(negedge clk_50);
      bus.spi_sck = 1'b1;
      rx[i] = bus.spi_so;
      repeat (HALF) @(negedge clk_50);
      bus.spi_sck = 1'b0;
    end
  endtask

  task automatic end_txn(input string tag);
    bus.spi_cs = 1'b1;
    repeat (HALF + 8) @(negedge clk_50);
    oe_allow = 1'b0;
    check({tag, "_busy_idle"}, 32'(bus.busy), 32'd0);
    check({tag, "_oe_idle"}, 32'(bus.spi_so_oe), 32'd0);
    check({tag, "_so_idle"}, 32'(bus.spi_so), 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int we0, er0;
    logic [7:0] rb, wd;
    logic [ADDR_W-1:0] a;
    wr_t w;
    we0 = we_seen;
    er0 = err_seen;
    a = v.addr[ADDR_W-1:0];
    bus.spi_cs = 1'b0;
    repeat (HALF) @(negedge clk_50);
    spi_bits(v.op, 8, rb);
    check({tag, "_busy"}, 32'(bus.busy), 32'd1);
    for (int i = 2; i >= 0; i--) spi_bits(v.addr[i*8 +: 8], 8, rb);
    if (v.op == 8'h03) oe_allow = 1'b1;
    for (int b = 0; b < v.nbytes; b++) begin
      wd = v.data[31 - 8*b -: 8];
      if (v.op == 8'h03) begin
        rd_q.push_back(shadow[a]);
      end else if (v.op == 8'h02) begin
        w.a = a;
        w.d = wd;
        wr_q.push_back(w);
        shadow[a] = wd;
      end
      spi_bits(wd, 8, rb);
      if (v.op == 8'h03) begin
        check({tag, "_rd_byte"}, 32'(rb), 32'(rd_q.pop_front()));
        check({tag, "_oe_data"}, 32'(bus.spi_so_oe), 32'd1);
      end
      a = a + ADDR_W'(1);
    end
    end_txn(tag);
    check({tag, "_cmd_err"}, 32'(err_seen - er0), 32'(v.exp_err));
    check({tag, "_we_count"}, 32'(we_seen - we0), 32'(v.exp_we));
    check({tag, "_wr_q_empty"}, 32'(wr_q.size()), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] rb;
    int we0;
    vec_t v;

    vecs[0] = '{op: 8'h03, addr: 24'h000005, nbytes: 2, data: 32'h0,         exp_err: 0, exp_we: 0};
    vecs[1] = '{op: 8'h02, addr: 24'h0003FF, nbytes: 2, data: 32'h1122_0000, exp_err: 0, exp_we: 2};
    vecs[2] = '{op: 8'h9F, addr: 24'h123456, nbytes: 0, data: 32'h0,         exp_err: 1, exp_we: 0};
    vecs[3] = '{op: 8'h03, addr: 24'h0003FF, nbytes: 2, data: 32'h0,         exp_err: 0, exp_we: 0};
    vecs[4] = '{op: 8'h02, addr: 24'hABC010, nbytes: 3, data: 32'hDEAD_BE00, exp_err: 0, exp_we: 3};
    vecs[5] = '{op: 8'h03, addr: 24'hFFF010, nbytes: 3, data: 32'h0,         exp_err: 0, exp_we: 0};
    vecs[6] = '{op: 8'h03, addr: 24'h000000, nbytes: 4, data: 32'h0,         exp_err: 0, exp_we: 0};

    for (int i = 0; i < DEPTH; i++) shadow[i] = init_byte(i);
    bus.spi_cs  = 1'b1;
    bus.spi_sck = 1'b0;
    bus.spi_si  = 1'b0;
    reset       = 1'b1;
    ram_init    = 1'b1;
    repeat (3) @(negedge clk_50);
    ram_init = 1'b0;
    check("rst_so", 32'(bus.spi_so), 32'd0);
    check("rst_oe", 32'(bus.spi_so_oe), 32'd0);
    check("rst_we", 32'(bus.mem_we), 32'd0);
    check("rst_raddr", 32'(bus.mem_raddr), 32'd0);
    check("rst_waddr", 32'(bus.mem_waddr), 32'd0);
    check("rst_wdata", 32'(bus.mem_wdata), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_cmd_err", 32'(bus.cmd_err), 32'd0);
    reset = 1'b0;
    repeat (10) @(negedge clk_50);

    for (int i = 0; i < 7; i++) begin
      v = vecs[i];
      run_vec(v, $sformatf("vec%0d", i));
      repeat (6) @(negedge clk_50);
    end

    // Truncated write byte must be dropped; the old RAM byte stays readable.
    we0 = we_seen;
    bus.spi_cs = 1'b0;
    repeat (HALF) @(negedge clk_50);
    spi_bits(8'h02, 8, rb);
    spi_bits(8'h00, 8, rb);
    spi_bits(8'h00, 8, rb);
    spi_bits(8'h20, 8, rb);
    spi_bits(8'h5A, 5, rb);
    end_txn("partial_wr");
    check("partial_wr_no_we", 32'(we_seen - we0), 32'd0);
    v = '{op: 8'h03, addr: 24'h000020, nbytes: 1, data: 32'h0, exp_err: 0, exp_we: 0};
    run_vec(v, "partial_rd");
    repeat (6) @(negedge clk_50);

    // Reset pulse in the middle of the address phase; the frame must be abandoned.
    we0 = we_seen;
    bus.spi_cs = 1'b0;
    repeat (HALF) @(negedge clk_50);
    spi_bits(8'h03, 8, rb);
    spi_bits(8'h00, 8, rb);
    spi_bits(8'h00, 4, rb);
    reset = 1'b1;
    @(negedge clk_50);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_raddr", 32'(bus.mem_raddr), 32'd0);
    reset = 1'b0;
    spi_bits(8'h00, 4, rb);
    spi_bits(8'h00, 8, rb);
    spi_bits(8'h00, 8, rb);
    spi_bits(8'h00, 8, rb);
    check("midrst_busy_after", 32'(bus.busy), 32'd0);
    check("midrst_no_read", 32'(bus.mem_raddr), 32'd0);
    end_txn("midrst");
    check("midrst_no_we", 32'(we_seen - we0), 32'd0);
    v = '{op: 8'h03, addr: 24'h000000, nbytes: 1, data: 32'h0, exp_err: 0, exp_we: 0};
    run_vec(v, "midrst_rd");

    check("oe_outside_data", 32'(oe_bad), 32'd0);
    check("rd_q_empty", 32'(rd_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
